uart_tx: RTL and testbench

- UART transmitter, 8N1 framing (8 data bits, no parity, 1 stop bit); LSB first; line idles high.
- Companion to the RX path. Shares the same 2-bit baud_rate select encoding as the RX baud generator, so both ends agree on line rate.
- Accepts one byte per valid/ready handshake. Generates its own 1x bit tick internally.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_baud_tick.sv | 29 ++
 rtl/uart_tx.sv | 134 +++++++++++++
 tb/tb_uart_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state and baud_rate encodings, default base rate and the
// bit-period divisor used by both the TX and RX baud generators.
package uart_pkg;

    localparam int unsigned BaudBaseDefault = 2400;
    localparam int unsigned DivWidth        = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    // Each step doubles the line rate relative to the base rate.
    typedef enum logic [1:0] {
        BaudX1 = 2'b00,
        BaudX2 = 2'b01,
        BaudX4 = 2'b10,
        BaudX8 = 2'b11
    } baud_rate_e;

    // Clocks per bit, rounded to nearest: (clk_freq + b/2) / b with b = baud_base << rate.
    function automatic logic [DivWidth-1:0] baud_div(input int unsigned clk_freq,
                                                     input int unsigned baud_base,
                                                     input logic [1:0]  rate);
        int unsigned b;
        b = baud_base << rate;
        return DivWidth'((clk_freq + b / 2) / b);
    endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period timer for uart_tx: 16-bit down-counter reloaded with the divisor, pulsing
// bit_end on the last clock of every bit period.
module uart_tx_baud_tick
    import uart_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                run,
    input  logic [DivWidth-1:0] div,
    output logic                bit_end
);

    logic [DivWidth-1:0] cnt_q;

    assign bit_end = run && (cnt_q == '0);

    // Loading div-1 on the frame-start edge makes every bit exactly div clocks long.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start || bit_end) begin
            cnt_q <= div - DivWidth'(1);
        end else if (run) begin
            cnt_q <= cnt_q - DivWidth'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, line idles high; one byte per valid/ready handshake.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_BASE  = BaudBaseDefault,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] baud_rate,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx
);

    localparam logic [DivWidth-1:0] Div1x = baud_div(CLK_FREQ, BAUD_BASE, BaudX1);
    localparam logic [DivWidth-1:0] Div2x = baud_div(CLK_FREQ, BAUD_BASE, BaudX2);
    localparam logic [DivWidth-1:0] Div4x = baud_div(CLK_FREQ, BAUD_BASE, BaudX4);
    localparam logic [DivWidth-1:0] Div8x = baud_div(CLK_FREQ, BAUD_BASE, BaudX8);

    uart_state_e         state_q;
    logic [7:0]          shift_q;
    logic [2:0]          bit_cnt_q;
    logic [DivWidth-1:0] div_q;
    logic [DivWidth-1:0] div_sel;
    logic [DivWidth-1:0] div_cur;
    logic                accept;
    logic                bit_end;

`ifdef UART_TX_PARITY_EN
    localparam logic ParityOdd = (PARITY_ODD != 0);
    logic parity_q;
`endif

    always_comb begin
        div_sel = Div1x;
        case (baud_rate)
            BaudX1:  div_sel = Div1x;
            BaudX2:  div_sel = Div2x;
            BaudX4:  div_sel = Div4x;
            BaudX8:  div_sel = Div8x;
            default: div_sel = Div1x;
        endcase
    end

    assign accept  = (state_q == StIdle) && tx_valid && tx_ready;
    // The rate is frozen at acceptance; later baud_rate changes only affect the next byte.
    assign div_cur = accept ? div_sel : div_q;

    uart_tx_baud_tick u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .run     (state_q != StIdle),
        .div     (div_cur),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            tx        <= 1'b1;
            tx_ready  <= 1'b1;
            tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        shift_q   <= tx_data;
                        div_q     <= div_sel;
                        bit_cnt_q <= '0;
                        tx        <= 1'b0;
                        tx_ready  <= 1'b0;
                        state_q   <= StStart;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= (^tx_data) ^ ParityOdd;
`endif
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        tx      <= shift_q[0];
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx      <= parity_q;
                            state_q <= StParity;
`else
                            tx      <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            tx        <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        tx      <= 1'b1;
                        state_q <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        tx_done  <= 1'b1;
                        tx_ready <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx, run at a 1 MHz clock so frames stay short
// (DIV = 417 / 208 / 104 / 52); the default 50 MHz divisors are checked via the package.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int unsigned ClkFreq = 1_000_000;
`ifdef UART_TX_PARITY_EN
    localparam int NBits = 11;
`else
    localparam int NBits = 10;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] baud_rate;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx;

    int n_tests;
    int n_fail;

    uart_tx #(
        .CLK_FREQ   (ClkFreq),
        .BAUD_BASE  (2400),
        .PARITY_ODD (0)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .baud_rate (baud_rate),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_done   (tx_done),
        .tx        (tx)
    );

`ifdef UART_TX_PARITY_EN
    logic tx_ready_odd;
    logic tx_done_odd;
    logic tx_odd;
    logic par_main;
    logic par_odd;

    uart_tx #(
        .CLK_FREQ   (ClkFreq),
        .BAUD_BASE  (2400),
        .PARITY_ODD (1)
    ) u_dut_odd (
        .clk       (clk),
        .rst       (rst),
        .baud_rate (baud_rate),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready_odd),
        .tx_done   (tx_done_odd),
        .tx        (tx_odd)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int div_of(input int r);
        case (r)
            0:       return 417;
            1:       return 208;
            2:       return 104;
            default: return 52;
        endcase
    endfunction

    function automatic int div_default(input int r);
        case (r)
            0:       return 20833;
            1:       return 10417;
            2:       return 5208;
            default: return 2604;
        endcase
    endfunction

    function automatic logic [NBits-1:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    // Waits for tx_ready, presents a byte and returns just after the acceptance edge.
    task automatic start_frame(input logic [7:0] data, input logic [1:0] rate, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 50000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, 32'(n < 50000), 32'd1);
        tx_data   = data;
        baud_rate = rate;
        tx_valid  = 1'b1;
        @(posedge clk);
    endtask

    // Samples one frame, c = clocks since the acceptance edge; checks every bit at its
    // first, centre and last clock plus tx_done / tx_ready timing.
    task automatic measure_frame(input logic [7:0] data, input int div, input bit hold,
                                 input logic [7:0] next_data, input int chg_at,
                                 input logic [1:0] chg_rate, input string tag,
                                 output logic [7:0] dec, output int dones);
        logic [NBits-1:0] exp_v;
        logic [NBits-1:0] first_v;
        logic [NBits-1:0] mid_v;
        logic [NBits-1:0] last_v;
        int               done_at;
        int               ready_at;
        int               b;
        int               o;
        exp_v    = frame_bits(data);
        first_v  = '0;
        mid_v    = '0;
        last_v   = '0;
        done_at  = -1;
        ready_at = -1;
        dones    = 0;
        for (int c = 0; c <= NBits * div; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (hold) tx_data = next_data;
                else tx_valid = 1'b0;
            end
            if (c == chg_at) baud_rate = chg_rate;
            if (c < NBits * div) begin
                b = c / div;
                o = c % div;
                if (o == 0) first_v[b] = tx;
                if (o == div / 2) mid_v[b] = tx;
                if (o == div - 1) last_v[b] = tx;
`ifdef UART_TX_PARITY_EN
                if (b == 9 && o == div / 2) begin
                    par_main = tx;
                    par_odd  = tx_odd;
                end
`endif
            end
            if (tx_done) begin
                dones++;
                if (done_at < 0) done_at = c;
            end
            if (tx_ready && ready_at < 0) ready_at = c;
        end
        dec = mid_v[8:1];
        check({tag, "_bit_first"}, 32'(first_v), 32'(exp_v));
        check({tag, "_bit_mid"}, 32'(mid_v), 32'(exp_v));
        check({tag, "_bit_last"}, 32'(last_v), 32'(exp_v));
        check({tag, "_done_at"}, done_at, NBits * div);
        check({tag, "_ready_at"}, ready_at, NBits * div);
        check({tag, "_done_count"}, dones, 1);
    endtask

    initial begin
        logic [7:0] dec;
        int         d0;
        int         d1;
        int         bad;

        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        baud_rate = 2'b10;

        @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_ready", 32'(tx_ready), 32'd1);
        check("reset_done", 32'(tx_done), 32'd0);

        for (int r = 0; r < 4; r++) begin
            check($sformatf("div_default_%0d", r), 32'(baud_div(50_000_000, 2400, 2'(r))),
                  div_default(r));
        end

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single frame, 0xA5 at rate 2'b10: line 0,1,0,1,0,0,1,0,1,1.
        start_frame(8'hA5, 2'b10, "a5");
        measure_frame(8'hA5, 104, 1'b0, 8'h00, -1, 2'b00, "a5", dec, d0);
        check("a5_decode", 32'(dec), 32'h0000_00A5);

        // All four rates with alternating data, so every bit boundary is an edge.
        for (int r = 0; r < 4; r++) begin
            start_frame(8'h55, 2'(r), $sformatf("rate%0d", r));
            measure_frame(8'h55, div_of(r), 1'b0, 8'h00, -1, 2'b00, $sformatf("rate%0d", r),
                          dec, d0);
            check($sformatf("rate%0d_decode", r), 32'(dec), 32'h0000_0055);
        end

        // Back-to-back: tx_valid held high, second start bit right after a 1-clock gap.
        start_frame(8'h00, 2'b11, "b2b0");
        measure_frame(8'h00, 52, 1'b1, 8'hFF, -1, 2'b00, "b2b0", dec, d0);
        measure_frame(8'hFF, 52, 1'b0, 8'h00, -1, 2'b00, "b2b1", dec, d1);
        check("b2b_total_done", d0 + d1, 2);
        check("b2b_decode", 32'(dec), 32'h0000_00FF);

        // Rate switched to 2'b11 during data bit 3; this frame must stay at 104.
        start_frame(8'h3C, 2'b10, "chg_cur");
        measure_frame(8'h3C, 104, 1'b0, 8'h00, 4 * 104 + 20, 2'b11, "chg_cur", dec, d0);
        start_frame(8'hC3, 2'b11, "chg_next");
        measure_frame(8'hC3, 52, 1'b0, 8'h00, -1, 2'b00, "chg_next", dec, d0);

        // Reset during data bit 1 (a 0 bit of 0xA5) at rate 2'b10.
        start_frame(8'hA5, 2'b10, "rst_mid");
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (249) @(negedge clk);
        check("rst_mid_pre_tx", 32'(tx), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_ready", 32'(tx_ready), 32'd1);
        check("rst_mid_done", 32'(tx_done), 32'd0);
        #99;
        rst = 1'b0;
        bad = 0;
        repeat (12 * 104) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) bad++;
        end
        check("rst_mid_quiet", bad, 0);

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones: even parity bit 1, odd parity bit 0.
        start_frame(8'h07, 2'b11, "par");
        measure_frame(8'h07, 52, 1'b0, 8'h00, -1, 2'b00, "par", dec, d0);
        check("par_even_bit", 32'(par_main), 32'd1);
        check("par_odd_bit", 32'(par_odd), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
